square_unit: RTL and testbench

Sequential shift-add squarer: computes Q = A² for an unsigned W_IN-bit operand, one partial product per clock, under a start/busy/done handshake. It is the inverse-direction companion of the SquareRoot block. It sits in the same arithmetic datapath, turning roots back into squared magnitudes, for example for distance comparisons and for self-checking the root unit in hardware. Fixed latency by default; optional early exit.

---
 rtl/square_pkg.sv | 13 +
 rtl/square_unit_if.sv | 31 +++
 rtl/square_unit.sv | 78 +++++++
 tb/tb_square_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/square_pkg.sv
// Shared constants and types for the shift-add squarer.
// Default operand width, FSM state encoding and iteration-counter width.
package square_pkg;

   localparam int SQ_W_IN   = 12;
   localparam int SQ_CNT_W  = $clog2(SQ_W_IN);

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } sq_state_t;

endpackage

// File: rtl/square_unit_if.sv
// Start/busy/done request bus of the squarer; master issues operands, slave returns squares.
// No backpressure: the master must watch busy, starts issued while busy are dropped.
interface square_unit_if
   import square_pkg::*;
#(
   parameter int W_IN = SQ_W_IN
) ();

   logic              start;
   logic [W_IN-1:0]   A;
   logic [2*W_IN-1:0] Q;
   logic              busy;
   logic              done;

   modport master (
      output start,
      output A,
      input  Q,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  A,
      output Q,
      output busy,
      output done
   );

endinterface

// File: rtl/square_unit.sv
// Sequential shift-add squarer Q = A*A, one partial product per clock; W_IN+1 edges start-to-done
// (data-dependent when SQUARE_UNIT_EARLY_EXIT_EN is defined). Starts are ignored while busy.
module square_unit
   import square_pkg::*;
#(
   parameter int W_IN = SQ_W_IN
) (
   input  logic          clk,
   input  logic          rst_,
   square_unit_if.slave  bus
);

   localparam int RW = 2 * W_IN;
   localparam int CW = (W_IN == SQ_W_IN) ? SQ_CNT_W : ((W_IN > 1) ? $clog2(W_IN) : 1);

   sq_state_t       state;
   logic [W_IN-1:0] mcand;
   logic [W_IN-1:0] mult;
   logic [RW-1:0]   acc;
   logic [RW-1:0]   acc_nxt;
   logic [RW-1:0]   pp;
   logic [CW-1:0]   cnt;
   logic            last;

   // One partial product per iteration; the sum of this edge feeds Q directly on the last one.
   always_comb begin
      pp = '0;
      if (mult[0]) begin
         pp = RW'(mcand) << cnt;
      end
      acc_nxt = acc + pp;
`ifdef SQUARE_UNIT_EARLY_EXIT_EN
      last = (cnt == CW'(W_IN - 1)) || ((mult >> 1) == '0);
`else
      last = (cnt == CW'(W_IN - 1));
`endif
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         state    <= IDLE;
         mcand    <= '0;
         mult     <= '0;
         acc      <= '0;
         cnt      <= '0;
         bus.Q    <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mcand    <= bus.A;
                  mult     <= bus.A;
                  acc      <= '0;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               acc  <= acc_nxt;
               mult <= mult >> 1;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  bus.Q    <= acc_nxt;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_square_unit.sv
// Directed bench for square_unit: scoreboard of expected squares and start-to-done latencies.
// Latency counts edges inclusively from the accepting edge to the completion edge.
module tb_square_unit;
   import square_pkg::*;

   localparam int W = SQ_W_IN;

   logic clk = 1'b0;
   logic rst_;
   always #5 clk = ~clk;

   square_unit_if #(.W_IN(W)) bus ();

   square_unit #(.W_IN(W)) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [2*W-1:0] sb_q[$];
   int             sb_lat[$];

   int   ecnt = 0;
   int   acc_e = 0;
   int   last_done_e = 0;
   int   prev_done_e = 0;
   logic busy_q = 1'b0;
   logic done_q = 1'b0;

   always @(posedge clk) ecnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int lat_of(input logic [W-1:0] a);
`ifdef SQUARE_UNIT_EARLY_EXIT_EN
      int it = 1;
      for (int i = 0; i < W; i++) begin
         if (a[i]) it = i + 1;
      end
      return it + 1;
`else
      return W + 1;
`endif
   endfunction

   task automatic push(input logic [W-1:0] a);
      logic [2*W-1:0] m;
      m = a;
      sb_q.push_back(m * m);
      sb_lat.push_back(lat_of(a));
   endtask

   // Output monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      if (!rst_) begin
         if (done_q) chk("done_width", bus.done, 1'b0);
         if (busy_q && !bus.busy) chk("busy_fall_with_done", bus.done, 1'b1);
         if (bus.busy && !busy_q) acc_e = ecnt;
         if (bus.done) begin
            chk("done_busy_low", bus.busy, 1'b0);
            chk("done_expected", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
               chk("q_value", bus.Q, sb_q.pop_front());
               chk("latency", ecnt - acc_e + 1, sb_lat.pop_front());
               prev_done_e = last_done_e;
               last_done_e = ecnt;
            end
         end
      end
      busy_q = bus.busy;
      done_q = bus.done;
   end

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !bus.busy) break;
      end
      chk("drain", sb_q.size(), 0);
   endtask

   task automatic op(input logic [W-1:0] a);
      @(posedge clk);
      #1 bus.start = 1'b1;
      bus.A = a;
      push(a);
      @(posedge clk);
      #1 bus.start = 1'b0;
      bus.A = ~a;
      wait_idle();
   endtask

   logic [W-1:0] a_ign;
   bit           seen_low;

   initial begin
      rst_      = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_q", bus.Q, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      rst_ = 1'b0;

      op(12'hF00);
      op(12'hFFF);
      op(12'h000);
      op(12'h001);
      op(12'h010);

      // start held high across two operations
      @(posedge clk);
      #1 bus.start = 1'b1;
      bus.A = 12'd3;
      push(12'd3);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.busy) break;
      end
      chk("held_first_accept", bus.busy, 1'b1);
      bus.A = 12'd5;
      push(12'd5);
      seen_low = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bus.busy) seen_low = 1'b1;
         if (seen_low && bus.busy) break;
      end
      chk("held_second_accept", bus.busy, 1'b1);
      bus.start = 1'b0;
      wait_idle();
      chk("held_period", last_done_e - prev_done_e, lat_of(12'd5));

      // a start issued mid-operation must be dropped
`ifdef SQUARE_UNIT_EARLY_EXIT_EN
      a_ign = 12'h807;
`else
      a_ign = 12'h007;
`endif
      @(posedge clk);
      #1 bus.start = 1'b1;
      bus.A = a_ign;
      push(a_ign);
      @(posedge clk);
      #1 bus.start = 1'b0;
      bus.A = 12'h0AA;
      repeat (4) @(posedge clk);
      #1 bus.start = 1'b1;
      bus.A = 12'd9;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_idle();
      repeat (20) @(posedge clk);

      // reset in the middle of an operation
      @(posedge clk);
      #1 bus.start = 1'b1;
      bus.A = 12'hABC;
      push(12'hABC);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst_ = 1'b1;
      #1;
      chk("abort_q", bus.Q, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      sb_q.delete();
      sb_lat.delete();
      repeat (2) @(posedge clk);
      #1 rst_ = 1'b0;
      repeat (20) @(posedge clk);
      op(12'h5A5);

      for (int i = 0; i < 4; i++) begin
         op(W'($urandom_range(0, (1 << W) - 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
